// File: rtl/jk_bank_ctrl_if.sv
// Command channel into jk_bank_ctrl: a valid/ready handshake carrying the
// operation code, the bit mask and the load data.
interface jk_bank_ctrl_if #(
  parameter int N = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_mask;
  logic [N-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_mask,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_mask,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_ctrl.sv
// Command sequencer for a bank of JK flip-flops: drives J/K for one clock per
// command, then reads Q back and flags a mismatch against the expected value.
module jk_bank_ctrl #(
  parameter int N     = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_bank_ctrl_if.slave    cmd,
  output logic [N-1:0]     j,
  output logic [N-1:0]     k,
  input  logic [N-1:0]     q,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] OP_SET  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_TGL  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  state_t             state;
  state_t             state_nxt;
  logic [N-1:0]       exp_val;
  logic [N-1:0]       exp_nxt;
  logic [N-1:0]       j_nxt;
  logic [N-1:0]       k_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic [ERR_W-1:0]   err_cnt_nxt;
  logic               accept;

  function automatic logic [N-1:0] j_of(input logic [1:0] op,
                                        input logic [N-1:0] mask,
                                        input logic [N-1:0] data);
    logic [N-1:0] r;
    case (op)
      OP_SET:  r = mask;
      OP_CLR:  r = '0;
      OP_TGL:  r = mask;
      default: r = data & mask;
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] k_of(input logic [1:0] op,
                                        input logic [N-1:0] mask,
                                        input logic [N-1:0] data);
    logic [N-1:0] r;
    case (op)
      OP_SET:  r = '0;
      OP_CLR:  r = mask;
      OP_TGL:  r = mask;
      default: r = ~data & mask;
    endcase
    return r;
  endfunction

  // Value the bank must hold after the single J/K sampling edge.
  function automatic logic [N-1:0] exp_of(input logic [1:0] op,
                                          input logic [N-1:0] cur,
                                          input logic [N-1:0] mask,
                                          input logic [N-1:0] data);
    logic [N-1:0] r;
    case (op)
      OP_SET:  r = cur | mask;
      OP_CLR:  r = cur & ~mask;
      OP_TGL:  r = cur ^ mask;
      default: r = (cur & ~mask) | (data & mask);
    endcase
    return r;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    logic [ERR_W-1:0] r;
    if (&v) r = v;
    else    r = v + ERR_W'(1);
    return r;
  endfunction

  // Ready is decoded from the state register alone, never from cmd_valid.
  assign cmd.cmd_ready = (state == IDLE);
  assign accept        = cmd.cmd_valid && (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    j_nxt       = '0;
    k_nxt       = '0;
    exp_nxt     = exp_val;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    err_cnt_nxt = err_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = DRIVE;
          j_nxt     = j_of(cmd.cmd_op, cmd.cmd_mask, cmd.cmd_data);
          k_nxt     = k_of(cmd.cmd_op, cmd.cmd_mask, cmd.cmd_data);
          exp_nxt   = exp_of(cmd.cmd_op, q, cmd.cmd_mask, cmd.cmd_data);
        end
      end
      DRIVE: begin
        state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        if (q != exp_val) begin
          err_nxt     = 1'b1;
          err_cnt_nxt = sat_inc(err_cnt);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // J/K live only in DRIVE; reset drops them at once so an aborted command
  // cannot present a second sampling edge to the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      j       <= '0;
      k       <= '0;
      exp_val <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      j       <= j_nxt;
      k       <= k_nxt;
      exp_val <= exp_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

endmodule
